// File: rtl/traffic_pkg.sv
// Shared state encoding, phase codes and default durations for the traffic-light/gate sequencer.
package traffic_pkg;

  localparam logic [2:0] PH_RED_OPEN  = 3'd0;
  localparam logic [2:0] PH_GREEN     = 3'd1;
  localparam logic [2:0] PH_YELLOW    = 3'd2;
  localparam logic [2:0] PH_RED_CLOSE = 3'd3;
  localparam logic [2:0] PH_RED_HOLD  = 3'd4;
  localparam logic [2:0] PH_EMERG     = 3'd5;

  typedef enum logic [2:0] {
    S_RED_OPEN  = PH_RED_OPEN,
    S_GREEN     = PH_GREEN,
    S_YELLOW    = PH_YELLOW,
    S_RED_CLOSE = PH_RED_CLOSE,
    S_RED_HOLD  = PH_RED_HOLD,
    S_EMERG     = PH_EMERG
  } state_t;

  localparam int DEF_TICK_DIV    = 50_000_000;
  localparam int DEF_GREEN_S     = 5;
  localparam int DEF_YELLOW_S    = 2;
  localparam int DEF_RED_S       = 5;
  localparam int DEF_GATE_S      = 1;
  localparam int DEF_PED_GREEN_S = 2;

  // Successor in the normal light cycle; emergency exit is handled by the FSM itself.
  function automatic state_t next_phase(input state_t s);
    case (s)
      S_RED_OPEN:  next_phase = S_GREEN;
      S_GREEN:     next_phase = S_YELLOW;
      S_YELLOW:    next_phase = S_RED_CLOSE;
      S_RED_CLOSE: next_phase = S_RED_HOLD;
      S_RED_HOLD:  next_phase = S_RED_OPEN;
      default:     next_phase = S_RED_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into a one-cycle tick every TICK_DIV enabled cycles; clr restarts the count.
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign tick = en && (r_cnt == LAST);

  // clr beats en so a phase entry forced while frozen still restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_gate_sequencer.sv
// Light/gate phase FSM with per-phase countdown, pedestrian shortening and emergency override.
module traffic_gate_sequencer
  import traffic_pkg::*;
#(
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int GREEN_S     = DEF_GREEN_S,
  parameter int YELLOW_S    = DEF_YELLOW_S,
  parameter int RED_S       = DEF_RED_S,
  parameter int GATE_S      = DEF_GATE_S,
  parameter int PED_GREEN_S = DEF_PED_GREEN_S
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ped_req,
  input  logic       override,
  output logic       led_r,
  output logic       led_g,
  output logic       led_y,
  output logic       gate_cmd,
  output logic [3:0] countdown,
  output logic [2:0] phase
);

  state_t     r_state, w_next;
  logic [3:0] r_remaining, w_rem_next;
  logic       r_ped_q, r_ped_pend;
  logic       r_led_r, r_led_g, r_led_y, r_gate;
  logic       w_tick, w_clr, w_ped_edge, w_ped_clr;

  function automatic logic [3:0] dur_of(input state_t s);
    case (s)
      S_RED_OPEN, S_RED_CLOSE: dur_of = 4'(GATE_S);
      S_GREEN:                 dur_of = 4'(GREEN_S);
      S_YELLOW:                dur_of = 4'(YELLOW_S);
      S_RED_HOLD:              dur_of = 4'(RED_S);
      default:                 dur_of = 4'd0;
    endcase
  endfunction

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (w_clr),
    .tick (w_tick)
  );

  assign w_ped_edge = ped_req && !r_ped_q;
  // Every phase entry restarts the prescaler; it also stays cleared while in emergency.
  assign w_clr      = (w_next != r_state) || (r_state == S_EMERG);
  assign w_ped_clr  = (r_state == S_EMERG) || ((w_next == S_RED_HOLD) && (r_state != S_RED_HOLD));

  always_comb begin
    w_next     = r_state;
    w_rem_next = r_remaining;
    if (override) begin
      w_next     = S_EMERG;
      w_rem_next = 4'd0;
    end else if (r_state == S_EMERG) begin
      w_next     = S_RED_HOLD;
      w_rem_next = dur_of(S_RED_HOLD);
    end else if (en && (r_state == S_GREEN) && r_ped_pend &&
                 (r_remaining > 4'(PED_GREEN_S))) begin
      w_rem_next = 4'(PED_GREEN_S);
    end else if (w_tick) begin
      if (r_remaining == 4'd1) begin
        w_next     = next_phase(r_state);
        w_rem_next = dur_of(next_phase(r_state));
      end else begin
        w_rem_next = r_remaining - 4'd1;
      end
    end
  end

  // Lights and gate are decoded from the next state so they change on the same edge as it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_RED_OPEN;
      r_remaining <= 4'(GATE_S);
      r_ped_q     <= 1'b0;
      r_ped_pend  <= 1'b0;
      r_led_r     <= 1'b1;
      r_led_g     <= 1'b0;
      r_led_y     <= 1'b0;
      r_gate      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_remaining <= w_rem_next;
      r_ped_q     <= ped_req;
      if (w_ped_clr) begin
        r_ped_pend <= 1'b0;
      end else if (w_ped_edge) begin
        r_ped_pend <= 1'b1;
      end
      r_led_r <= (w_next inside {S_RED_OPEN, S_RED_CLOSE, S_RED_HOLD, S_EMERG});
      r_led_g <= (w_next == S_GREEN);
      r_led_y <= (w_next == S_YELLOW);
      r_gate  <= (w_next inside {S_RED_CLOSE, S_RED_HOLD, S_EMERG});
    end
  end

  assign led_r     = r_led_r;
  assign led_g     = r_led_g;
  assign led_y     = r_led_y;
  assign gate_cmd  = r_gate;
  assign countdown = r_remaining;
  assign phase     = r_state;

endmodule

// File: tb/tb_traffic_gate_sequencer.sv
// Directed bench: normal cycle table, pedestrian, override, enable-hold and async-reset sequences.
module tb_traffic_gate_sequencer;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       ped_req = 1'b0;
  logic       override = 1'b0;
  logic       led_r, led_g, led_y, gate_cmd;
  logic [3:0] countdown;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  typedef struct {
    int         edge_no;
    logic [2:0] ph;
    logic [3:0] cd;
  } vec_t;

  vec_t tbl[$];

  traffic_gate_sequencer #(
    .TICK_DIV(4), .GREEN_S(3), .YELLOW_S(2), .RED_S(3), .GATE_S(1), .PED_GREEN_S(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ped_req(ped_req), .override(override),
    .led_r(led_r), .led_g(led_g), .led_y(led_y), .gate_cmd(gate_cmd),
    .countdown(countdown), .phase(phase)
  );

  // clock/reset block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  // scoreboard
  task automatic check_out(input string name, input logic [2:0] ph, input logic [3:0] cd);
    logic [9:0] exp_v, got_v;
    logic       er, eg, ey, egate;
    er    = (ph == PH_RED_OPEN) || (ph == PH_RED_CLOSE) || (ph == PH_RED_HOLD) || (ph == PH_EMERG);
    eg    = (ph == PH_GREEN);
    ey    = (ph == PH_YELLOW);
    egate = (ph == PH_RED_CLOSE) || (ph == PH_RED_HOLD) || (ph == PH_EMERG);
    exp_v = {er, eg, ey, egate, cd, ph[1:0]};
    got_v = {led_r, led_g, led_y, gate_cmd, countdown, phase[1:0]};
    checks++;
    if (got_v !== exp_v || phase !== ph) begin
      errors++;
      $display("FAIL %s: got r=%b g=%b y=%b gate=%b cd=%0d ph=%0d, expected r=%b g=%b y=%b gate=%b cd=%0d ph=%0d",
               name, led_r, led_g, led_y, gate_cmd, countdown, phase, er, eg, ey, egate, cd, ph);
    end
  endtask

  // driver tasks
  task automatic wait_edge(input int n);
    int guard = 0;
    while (edge_n < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (edge_n != n) begin
      checks++;
      errors++;
      $display("FAIL wait_e%0d: at edge %0d, required edge %0d", n, edge_n, n);
    end
  endtask

  task automatic check_at(input int n, input logic [2:0] ph, input logic [3:0] cd, input string name);
    wait_edge(n);
    check_out($sformatf("%s_e%0d", name, n), ph, cd);
  endtask

  task automatic run_table(input int max_edge);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].edge_no <= max_edge)
        check_at(tbl[i].edge_no, tbl[i].ph, tbl[i].cd, "cycle");
    end
  endtask

  initial begin
    // normal cycle after reset: {edge, phase, countdown}
    tbl.push_back('{0,  PH_RED_OPEN,  4'd1});
    tbl.push_back('{3,  PH_RED_OPEN,  4'd1});
    tbl.push_back('{4,  PH_GREEN,     4'd3});
    tbl.push_back('{7,  PH_GREEN,     4'd3});
    tbl.push_back('{8,  PH_GREEN,     4'd2});
    tbl.push_back('{11, PH_GREEN,     4'd2});
    tbl.push_back('{12, PH_GREEN,     4'd1});
    tbl.push_back('{15, PH_GREEN,     4'd1});
    tbl.push_back('{16, PH_YELLOW,    4'd2});
    tbl.push_back('{19, PH_YELLOW,    4'd2});
    tbl.push_back('{20, PH_YELLOW,    4'd1});
    tbl.push_back('{23, PH_YELLOW,    4'd1});
    tbl.push_back('{24, PH_RED_CLOSE, 4'd1});
    tbl.push_back('{27, PH_RED_CLOSE, 4'd1});
    tbl.push_back('{28, PH_RED_HOLD,  4'd3});
    tbl.push_back('{32, PH_RED_HOLD,  4'd2});
    tbl.push_back('{36, PH_RED_HOLD,  4'd1});
    tbl.push_back('{39, PH_RED_HOLD,  4'd1});
    tbl.push_back('{40, PH_RED_OPEN,  4'd1});
    tbl.push_back('{43, PH_RED_OPEN,  4'd1});
    tbl.push_back('{44, PH_GREEN,     4'd3});

    repeat (3) @(negedge clk);
    check_out("reset_hold", PH_RED_OPEN, 4'd1);
    rst = 1'b0;
    run_table(44);

    // pedestrian pulse two cycles after green entry, then a repeat press
    wait_edge(46);
    ped_req = 1'b1;
    check_at(47, PH_GREEN, 4'd3, "ped_latch");
    ped_req = 1'b0;
    check_at(48, PH_GREEN, 4'd1, "ped_short");
    ped_req = 1'b1;
    wait_edge(49);
    ped_req = 1'b0;
    check_at(51, PH_GREEN,     4'd1, "ped_green_end");
    check_at(52, PH_YELLOW,    4'd2, "ped_yellow");
    check_at(60, PH_RED_CLOSE, 4'd1, "ped_close");
    check_at(64, PH_RED_HOLD,  4'd3, "ped_hold");
    check_at(76, PH_RED_OPEN,  4'd1, "ped_open");
    check_at(80, PH_GREEN,     4'd3, "g2_entry");
    check_at(81, PH_GREEN,     4'd3, "ped_cleared");
    check_at(84, PH_GREEN,     4'd2, "g2_tick");

    // override for 10 cycles mid-green
    wait_edge(85);
    override = 1'b1;
    check_at(86, PH_EMERG, 4'd0, "emerg_entry");
    check_at(90, PH_EMERG, 4'd0, "emerg_hold");
    check_at(95, PH_EMERG, 4'd0, "emerg_last");
    override = 1'b0;
    check_at(96,  PH_RED_HOLD, 4'd3, "emerg_exit");
    check_at(100, PH_RED_HOLD, 4'd2, "emerg_hold_tick");
    check_at(104, PH_RED_HOLD, 4'd1, "emerg_hold_tick");
    check_at(108, PH_RED_OPEN, 4'd1, "emerg_reopen");
    check_at(112, PH_GREEN,    4'd3, "g3_entry");

    // enable low for 20 cycles mid-yellow
    check_at(124, PH_YELLOW, 4'd2, "y3_entry");
    check_at(125, PH_YELLOW, 4'd2, "y3_pre_hold");
    en = 1'b0;
    check_at(130, PH_YELLOW, 4'd2, "en_frozen");
    check_at(145, PH_YELLOW, 4'd2, "en_frozen_end");
    en = 1'b1;
    check_at(147, PH_YELLOW,    4'd2, "en_resume");
    check_at(148, PH_YELLOW,    4'd1, "en_resume_tick");
    check_at(151, PH_YELLOW,    4'd1, "en_yellow_end");
    check_at(152, PH_RED_CLOSE, 4'd1, "en_close");
    check_at(156, PH_RED_HOLD,  4'd3, "hold4_entry");
    check_at(158, PH_RED_HOLD,  4'd3, "hold4_mid");

    // asynchronous reset between edges in red hold
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_out("async_reset", PH_RED_OPEN, 4'd1);
    @(posedge clk);
    @(negedge clk);
    check_out("reset_held", PH_RED_OPEN, 4'd1);
    rst = 1'b0;
    run_table(28);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
